// File: rtl/multi.sv
// Unsigned Q16.16 x Q16.16 multiplier, two-stage pipeline, throughput one per cycle.
// Stage 1 registers the three aligned partial-product terms; stage 2 registers the truncated Q16.16 sum.
module multi (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] resultH,
    output logic [63:0] resultM,
    output logic [63:0] resultL,
    output logic [31:0] result,
    output logic [15:0] resultE,
    output logic [15:0] resultF
);

    logic [15:0] a_int;
    logic [15:0] a_frac;
    logic [15:0] b_int;
    logic [15:0] b_frac;

    logic [31:0] prod_ii;
    logic [31:0] prod_if;
    logic [31:0] prod_fi;
    logic [31:0] prod_ff;
    logic [32:0] mid_sum;

    logic [63:0] term_h;
    logic [63:0] term_m;
    logic [63:0] term_l;

    logic [31:0] sum_q16;

    assign a_int  = A[31:16];
    assign a_frac = A[15:0];
    assign b_int  = B[31:16];
    assign b_frac = B[15:0];

    assign prod_ii = {16'd0, a_int}  * {16'd0, b_int};
    assign prod_if = {16'd0, a_int}  * {16'd0, b_frac};
    assign prod_fi = {16'd0, a_frac} * {16'd0, b_int};
    assign prod_ff = {16'd0, a_frac} * {16'd0, b_frac};

    // 33-bit middle sum so the carry of Ai*Bf + Af*Bi survives.
    assign mid_sum = {1'b0, prod_if} + {1'b0, prod_fi};

    assign term_h = {prod_ii, 32'd0};
    assign term_m = {15'd0, mid_sum, 16'd0};
    assign term_l = {32'd0, prod_ff};

    always_ff @(posedge clk) begin
        if (rst) begin
            resultH <= 64'd0;
            resultM <= 64'd0;
            resultL <= 64'd0;
        end else begin
            resultH <= term_h;
            resultM <= term_m;
            resultL <= term_l;
        end
    end

    // Only resultL has bits below 16, and they cannot carry upward, so a
    // 32-bit add of the [47:16] slices equals P[47:16] exactly.
    assign sum_q16 = resultH[47:16] + resultM[47:16] + resultL[47:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 32'd0;
        end else begin
            result <= sum_q16;
        end
    end

    assign resultE = result[31:16];
    assign resultF = result[15:0];

endmodule

// File: tb/tb_multi.sv
// Bench for multi: directed vectors from the datasheet plus random operands,
// compared against a full-width 64-bit product model with a result queue.
module tb_multi;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] resultH;
    logic [63:0] resultM;
    logic [63:0] resultL;
    logic [31:0] result;
    logic [15:0] resultE;
    logic [15:0] resultF;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    multi dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .resultH (resultH),
        .resultM (resultM),
        .resultL (resultL),
        .result  (result),
        .resultE (resultE),
        .resultF (resultF)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // reference model: plain arithmetic on the operand halves and full product
    function automatic logic [63:0] model_h(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y;
        x = 64'(a[31:16]);
        y = 64'(b[31:16]);
        return (x * y) << 32;
    endfunction

    function automatic logic [63:0] model_m(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ai, af, bi, bf;
        ai = 64'(a[31:16]);
        af = 64'(a[15:0]);
        bi = 64'(b[31:16]);
        bf = 64'(b[15:0]);
        return (ai * bf + af * bi) << 16;
    endfunction

    function automatic logic [63:0] model_l(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y;
        x = 64'(a[15:0]);
        y = 64'(b[15:0]);
        return x * y;
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[47:16];
    endfunction

    // driver: present operands on the falling edge, check just after the rising edge
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [31:0] exp_r;
        @(negedge clk);
        A   = a;
        B   = b;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            check("rst_H", resultH, 64'd0);
            check("rst_M", resultM, 64'd0);
            check("rst_L", resultL, 64'd0);
            check("rst_result", 64'(result), 64'd0);
            check("rst_E", 64'(resultE), 64'd0);
            check("rst_F", 64'(resultF), 64'd0);
        end else begin
            if (exp_q.size() > 0) exp_r = exp_q.pop_front();
            else exp_r = 32'd0;
            check("result", 64'(result), 64'(exp_r));
            check("resultE", 64'(resultE), 64'(exp_r[31:16]));
            check("resultF", 64'(resultF), 64'(exp_r[15:0]));
            check("resultH", resultH, model_h(a, b));
            check("resultM", resultM, model_m(a, b));
            check("resultL", resultL, model_l(a, b));
            exp_q.push_back(model_result(a, b));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        A     = 32'd0;
        B     = 32'd0;

        step(32'h1234_5678, 32'h9abc_def0, 1'b1);
        step(32'h0000_0000, 32'h0000_0000, 1'b1);

        // reference vector 1.5 * 3.25 with absolute datasheet values
        step(32'h0001_8000, 32'h0003_4000, 1'b0);
        check("ref_H", resultH, 64'h0000_0003_0000_0000);
        check("ref_M", resultM, 64'h0000_0001_c000_0000);
        check("ref_L", resultL, 64'h0000_0000_2000_0000);
        step(32'h0000_0001, 32'h0000_0001, 1'b0);
        check("ref_result", 64'(result), 64'h0000_0000_0004_e000);
        check("ref_E", 64'(resultE), 64'h0004);
        check("ref_F", 64'(resultF), 64'he000);
        check("trunc_L", resultL, 64'd1);

        // truncation, wrap and max, middle carry
        step(32'h0001_0000, 32'h0000_0001, 1'b0);
        check("trunc_result0", 64'(result), 64'd0);
        step(32'hffff_ffff, 32'hffff_ffff, 1'b0);
        check("trunc_result1", 64'(result), 64'd1);
        step(32'h0100_0000, 32'h0100_0000, 1'b0);
        check("max_result", 64'(result), 64'hfffe_0000);
        check("max_E", 64'(resultE), 64'hfffe);
        check("max_F", 64'(resultF), 64'h0000);
        step(32'h0000_ffff, 32'hffff_ffff, 1'b0);
        check("wrap_result", 64'(result), 64'd0);
        check("carry_M", resultM, 64'h0000_fffe_0001_0000);
        step(32'h0002_0000, 32'h0000_8000, 1'b0);
        check("carry_result", 64'(result), 64'hfffe_ffff);

        // back-to-back pipeline then reset while full
        step(32'h0003_0000, 32'h0002_0000, 1'b0);
        step(32'h0000_4000, 32'h0000_4000, 1'b0);
        step(32'h0005_0000, 32'h0000_0003, 1'b0);
        step(32'habcd_1234, 32'h5678_9abc, 1'b1);
        step(32'h0002_8000, 32'h0002_0000, 1'b0);
        step(32'h0000_0000, 32'h0000_0000, 1'b0);
        check("post_rst_result", 64'(result), 64'h0000_0000_0005_0000);

        // random operands, with occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            step($urandom, $urandom, ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 40; i++) begin
            step({16'($urandom_range(0, 3)), 16'($urandom)}, $urandom, 1'b0);
        end
        step(32'd0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi.md
# multi

Unsigned Q16.16 fixed-point multiplier for the datapath. It splits each 32-bit operand into a 16-bit integer half and a 16-bit fraction half, and forms three aligned partial-product terms. It sums them into a Q32.32 product and truncates that to a Q16.16 result. The partial terms and the integer/fraction split of the result are exported for downstream and debug use.

## Interface
- No parameters. Widths are fixed: 16-bit halves, 32-bit operands, 64-bit partial terms.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- A  in  32  operand A, unsigned Q16.16: {Ai[15:0], Af[15:0]}.
- B  in  32  operand B, unsigned Q16.16: {Bi[15:0], Bf[15:0]}.
- resultH  out  64  (Ai*Bi) << 32.
- resultM  out  64  (Ai*Bf + Af*Bi) << 16.
- resultL  out  64  Af*Bf, zero-extended.
- result  out  32  Q16.16 product = bits [47:16] of (resultH + resultM + resultL).
- resultE  out  16  integer part of the product, result[31:16].
- resultF  out  16  fraction part of the product, result[15:0].

## Operation
- Ai = A[31:16], Af = A[15:0], Bi = B[31:16], Bf = B[15:0]. All values are unsigned.
- Partial products:
  - Each 16x16 product is a full 32-bit result.
  - The middle sum Ai*Bf + Af*Bi is 33 bits wide; its carry is kept.
  - Each term is zero-extended to 64 bits before shifting.
- Full product P = resultH + resultM + resultL. P is a 64-bit Q32.32 value and is exact; it cannot overflow 64 bits.
- result = P[47:16].
  - Fraction bits P[15:0] are truncated. There is no rounding.
  - Integer bits P[63:48] are discarded. An integer part of 65536 or more wraps modulo 2^16. No saturation and no flag.
- resultE and resultF are pure slices of result. They are always consistent with result on the same cycle.
- The block has no handshake. A new operand pair is accepted every cycle and the pipeline is fully throughput-1.

## Timing
- Stage 1: A and B are sampled at edge N. resultH, resultM and resultL are registered and valid after edge N (latency 1).
- Stage 2: the sum of the stage-1 registers is registered into result, resultE and resultF, valid after edge N+1 (latency 2).
  - These outputs correspond to the same operands as resultH/M/L one cycle earlier.
- Reset: when rst=1 at a rising edge, every output register clears to 0 on that edge: resultH, resultM, resultL, result, resultE, resultF.
  - Reset takes priority over new data.
  - Any operands in flight are discarded. After rst deasserts, the first valid result/E/F appears 2 edges after the first sampled operands.
- Inputs may change every cycle. Outputs hold their registered values between edges.

## Test plan
- Reference vector: A=0x0001_8000 (1.5), B=0x0003_4000 (3.25).
  - After 1 cycle: resultH=0x0000_0003_0000_0000, resultM=0x0000_0001_C000_0000, resultL=0x0000_0000_2000_0000.
  - After 2 cycles: result=0x0004_E000, resultE=0x0004, resultF=0xE000 (4.875).
- Truncation: A=0x0000_0001, B=0x0000_0001 -> resultL=1, result=0x0000_0000. A=0x0001_0000, B=0x0000_0001 -> result=0x0000_0001.
- Wrap and max: A=B=0xFFFF_FFFF -> P=0xFFFF_FFFE_0000_0001, result=0xFFFE_0000, resultE=0xFFFE, resultF=0x0000.
  - A=0x0100_0000, B=0x0100_0000 (256*256) -> result=0x0000_0000 (integer wraps).
- Middle-term carry: A=0x0000_FFFF, B=0xFFFF_FFFF.
  - resultM = (0xFFFF*0xFFFF) << 16, with Af*Bi contributing and no carry lost.
  - result = 0xFFFE_FFFF: P[47:16] with P = 0x0000_FFFE_FFFF_0001 (fraction truncated).
- Pipelining: drive 3 different operand pairs on consecutive cycles -> results emerge on consecutive cycles in order, at latency 1 (H/M/L) and latency 2 (result/E/F).
- Reset mid-stream: assert rst for 1 cycle while the pipeline is full -> all outputs read 0 after that edge. Operands presented after release produce correct results 2 cycles later.
